// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register: valid/ready handshake, 2-entry skid buffer, sync flush.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int                 DATA_W    = 48,
  parameter int                 CTRL_W    = 8,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Builds the mask of low-order control bits; CTRL_W may be 0 or DATA_W.
  function automatic logic [DATA_W-1:0] ctrl_mask_f();
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < CTRL_W) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  localparam logic [DATA_W-1:0] CTRL_MASK = ctrl_mask_f();

  logic              m_v_r;
  logic [DATA_W-1:0] m_d_r;
  logic              s_v_r;
  logic [DATA_W-1:0] s_d_r;
  logic              accept_s;
  logic              drain_s;

  // Handshake qualifiers; in_ready depends only on a flop, so no comb path crosses stages.
  always_comb begin
    accept_s = 1'b0;
    drain_s  = 1'b0;
    if (in_valid && !s_v_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (m_v_r && out_ready) begin
      drain_s = 1'b1;
    end else begin
      drain_s = 1'b0;
    end
  end

  assign in_ready  = ~s_v_r;
  assign out_valid = m_v_r;

  // Bubbles present control bits as zero so write enables never fire on an empty slot.
  always_comb begin
    out_data = m_d_r;
    if (m_v_r) begin
      out_data = m_d_r;
    end else begin
      out_data = m_d_r & ~CTRL_MASK;
    end
  end

  // Main/skid storage update; skid always empties into main before a newer beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_r <= 1'b0;
      s_v_r <= 1'b0;
      m_d_r <= RESET_VAL;
      s_d_r <= RESET_VAL;
    end else if (flush) begin
      m_v_r <= 1'b0;
      s_v_r <= 1'b0;
    end else if (drain_s || !m_v_r) begin
      if (s_v_r) begin
        m_v_r <= 1'b1;
        m_d_r <= s_d_r;
        s_v_r <= 1'b0;
      end else if (accept_s) begin
        m_v_r <= 1'b1;
        m_d_r <= in_data;
      end else begin
        m_v_r <= 1'b0;
      end
    end else begin
      if (accept_s) begin
        s_v_r <= 1'b1;
        s_d_r <= in_data;
      end else begin
        s_v_r <= s_v_r;
      end
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of cycles a valid beat waits on downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (m_v_r && !out_ready && !flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: accepted beats are queued, drained beats are popped and compared.
module tb_pipe_stage_skid;

  localparam int                DATA_W    = 48;
  localparam int                CTRL_W    = 8;
  localparam int                CNT_W     = 4;
  localparam logic [DATA_W-1:0] RESET_VAL = 48'h1234_5678_9AFF;
  localparam logic [DATA_W-1:0] RESET_OUT = 48'h1234_5678_9A00;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  stall_cnt;

  int                nerr = 0;
  int                nchk = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic [CNT_W-1:0]  stall_exp = '0;
  logic              acc_last = 1'b0;

  pipe_stage_skid #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RESET_VAL(RESET_VAL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Sample at the falling edge, update the scoreboard, then step past the next rising edge.
  task automatic tick();
    logic mv;
    logic acc;
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    acc_last = 1'b0;
    if (rst) begin
      sb_q.delete();
      stall_exp = '0;
    end else begin
      mv  = (sb_q.size() > 0);
      acc = in_valid && (sb_q.size() < 2);
      check("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(mv));
      check("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
      if (!out_valid) check("bubble_ctrl", 64'(out_data[CTRL_W-1:0]), 64'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
      if (mv && !out_ready && !flush && stall_exp != {CNT_W{1'b1}}) stall_exp = stall_exp + 4'd1;
`endif
      acc_last = acc;
      if (flush) begin
        sb_q.delete();
      end else begin
        if (mv && out_ready) begin
          check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
          if (sb_q.size() > 0) begin
            exp_d = sb_q.pop_front();
            check("out_data", 64'(out_data), 64'(exp_d));
          end
        end
        if (acc) sb_q.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until the stage takes it (bounded).
  task automatic send(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (acc_last) break;
    end
    check("send_acc", 64'(acc_last), 64'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 48'h0000_0000_00FF;

    // 1 reset with in_valid asserted
    repeat (2) tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'(RESET_OUT));
    check("rst_stall", 64'(stall_cnt), 64'd0);

    // 2 streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) send(48'h5A5A_0000_0000 | 48'(i));
    in_valid = 1'b0;
    repeat (3) tick();
    check("stream_empty", 64'(sb_q.size()), 64'd0);

    // 3 backpressure: A in main, B in skid, C held upstream
    out_ready = 1'b0;
    send(48'hAAAA_0000_00A1);
    send(48'hBBBB_0000_00B2);
    in_valid = 1'b1; in_data = 48'hCCCC_0000_00C3;
    repeat (3) tick();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(48'hCCCC_0000_00C3);
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_empty", 64'(sb_q.size()), 64'd0);

    // 4 flush with main and skid full and a beat offered
    out_ready = 1'b0;
    send(48'hAAAA_1111_00A1);
    send(48'hBBBB_2222_00B2);
    in_valid = 1'b1; in_data = 48'hDDDD_3333_00D4; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_ov", 64'(out_valid), 64'd0);
    check("flush_ir", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    // flush drops a beat accepted in the same cycle
    out_ready = 1'b0;
    send(48'hAAAA_4444_00A5);
    in_valid = 1'b1; in_data = 48'hEEEE_5555_00E6; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    // 5 bubble with all-ones data on the input
    in_valid = 1'b0; in_data = {DATA_W{1'b1}};
    repeat (2) tick();
    check("bubble_ov", 64'(out_valid), 64'd0);
    check("bubble_bits", 64'(out_data[CTRL_W-1:0]), 64'd0);

    // 6 stall counter saturation and reset
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    send(48'h0F0F_0000_0077);
    in_valid = 1'b0;
    repeat (20) tick();
`ifdef PIPE_STAGE_STALL_CNT_EN
    check("stall_sat", 64'(stall_cnt), 64'd15);
`else
    check("stall_off", 64'(stall_cnt), 64'd0);
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    check("stall_rst", 64'(stall_cnt), 64'd0);
    check("rst2_ov", 64'(out_valid), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
